// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Constants shared by the fetch stage and the ID control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    typedef logic [1:0] jmp_ctrl_t;

    localparam jmp_ctrl_t NOT_JMP    = 2'b00;
    localparam jmp_ctrl_t JMP_DIR    = 2'b01;
    localparam jmp_ctrl_t JMP_REG    = 2'b10;
    localparam jmp_ctrl_t JMP_BRANCH = 2'b11;

    localparam logic NEXT_PC_SRC_SEQ     = 1'b0;
    localparam logic NEXT_PC_SRC_NOT_SEQ = 1'b1;

    localparam logic [31:0] HALT_CODE = 32'hFFFF_FFFF;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Control, debug-load and IF/ID signals of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 256
);
    localparam int c_ADDR_W = $clog2(IMEM_DEPTH);

    logic                i_enable;
    logic                i_stall;
    logic                i_next_pc_src;
    logic [1:0]          i_jmp_ctrl;
    logic [DATA_W-1:0]   i_jmp_dir_addr;
    logic [DATA_W-1:0]   i_jmp_reg_addr;
    logic [DATA_W-1:0]   i_branch_addr;
    logic                i_imem_wr;
    logic [c_ADDR_W-1:0] i_imem_addr;
    logic [DATA_W-1:0]   i_imem_data;
    logic [DATA_W-1:0]   o_pc;
    logic [DATA_W-1:0]   o_ifid_instr;
    logic [DATA_W-1:0]   o_ifid_pc4;
    logic                o_halt;

    modport master (
        output i_enable, i_stall, i_next_pc_src, i_jmp_ctrl,
               i_jmp_dir_addr, i_jmp_reg_addr, i_branch_addr,
               i_imem_wr, i_imem_addr, i_imem_data,
        input  o_pc, o_ifid_instr, o_ifid_pc4, o_halt
    );

    modport slave (
        input  i_enable, i_stall, i_next_pc_src, i_jmp_ctrl,
               i_jmp_dir_addr, i_jmp_reg_addr, i_branch_addr,
               i_imem_wr, i_imem_addr, i_imem_data,
        output o_pc, o_ifid_instr, o_ifid_pc4, o_halt
    );

endinterface
`default_nettype wire

// File: rtl/if_stage_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : Word array, asynchronous read, synchronous debug write.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              i_clk,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    output logic      [DATA_W-1:0] o_rd_data
);

    // Contents deliberately survive reset so a loaded program can be rerun.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : MIPS instruction fetch: PC, next-PC mux, IF/ID register, halt.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int                DATA_W     = 32,
    parameter int                IMEM_DEPTH = 256,
    parameter logic [DATA_W-1:0] HALT_CODE  = if_stage_pkg::HALT_CODE
) (
    input  wire logic  i_clk,
    input  wire logic  i_reset,
    if_stage_if.slave  bus
);
    import if_stage_pkg::*;

    localparam int c_ADDR_W = $clog2(IMEM_DEPTH);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ifid_instr;
    logic [DATA_W-1:0] r_ifid_pc4;
    logic [0:0]        r_state;

    logic [DATA_W-1:0] w_fetched;
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_target;
    logic [DATA_W-1:0] w_next_pc;
    logic              w_is_jmp;
    logic              w_imem_we;

    // Debug loads only land while the pipeline is frozen.
    assign w_imem_we = bus.i_imem_wr & ~bus.i_enable;

    instr_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_instr_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_imem_we),
        .i_wr_addr (bus.i_imem_addr),
        .i_wr_data (bus.i_imem_data),
        .i_rd_addr (r_pc[c_ADDR_W+1:2]),
        .o_rd_data (w_fetched)
    );

    assign w_pc4    = r_pc + DATA_W'(4);
    assign w_is_jmp = (bus.i_next_pc_src == NEXT_PC_SRC_NOT_SEQ) &&
                      (bus.i_jmp_ctrl != NOT_JMP);

    always_comb begin
        w_target = w_pc4;
        case (bus.i_jmp_ctrl)
            JMP_DIR:    w_target = bus.i_jmp_dir_addr;
            JMP_REG:    w_target = bus.i_jmp_reg_addr;
            JMP_BRANCH: w_target = bus.i_branch_addr;
            default:    w_target = w_pc4;
        endcase
    end

    assign w_next_pc = w_is_jmp ? (w_target & ~DATA_W'(3)) : w_pc4;

    // Delay slot: a redirect never flushes IF/ID, only retargets the PC.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_state      <= RUN;
        end else if (bus.i_enable && (r_state == RUN)) begin
            if (w_fetched == HALT_CODE) begin
                r_ifid_instr <= HALT_CODE;
                r_ifid_pc4   <= w_pc4;
                r_state      <= HALTED;
            end else if (!bus.i_stall) begin
                r_ifid_instr <= w_fetched;
                r_ifid_pc4   <= w_pc4;
                r_pc         <= w_next_pc;
            end
        end
    end

    assign bus.o_pc         = r_pc;
    assign bus.o_ifid_instr = r_ifid_instr;
    assign bus.o_ifid_pc4   = r_ifid_pc4;
    assign bus.o_halt       = (r_state == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed and random fetch-stage bench with a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;

    logic clk;
    logic rst;

    if_stage_if #(.DATA_W(32), .IMEM_DEPTH(256)) bus ();

    if_stage #(
        .DATA_W     (32),
        .IMEM_DEPTH (256),
        .HALT_CODE  (c_HALT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: architectural view of the fetch stage.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_halt;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, actual, expected);
    endtask

    task automatic set_in(input logic en, input logic stall, input logic src, input logic [1:0] jc,
                          input logic [31:0] dir, input logic [31:0] rg, input logic [31:0] br);
        bus.i_enable       = en;
        bus.i_stall        = stall;
        bus.i_next_pc_src  = src;
        bus.i_jmp_ctrl     = jc;
        bus.i_jmp_dir_addr = dir;
        bus.i_jmp_reg_addr = rg;
        bus.i_branch_addr  = br;
    endtask

    // One clock edge: advance the model from current inputs, then compare.
    task automatic tick();
        logic [31:0] f, tgt;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0;
        end else if (bus.i_enable && !m_halt) begin
            f = m_mem[(m_pc / 4) % 256];
            if (f == c_HALT) begin
                m_instr = c_HALT; m_pc4 = m_pc + 4; m_halt = 1;
            end else if (!bus.i_stall) begin
                m_instr = f; m_pc4 = m_pc + 4;
                if (bus.i_next_pc_src && bus.i_jmp_ctrl != 0) begin
                    tgt = (bus.i_jmp_ctrl == 1) ? bus.i_jmp_dir_addr :
                          (bus.i_jmp_ctrl == 2) ? bus.i_jmp_reg_addr : bus.i_branch_addr;
                    m_pc = {tgt[31:2], 2'b00};
                end else begin
                    m_pc = m_pc + 4;
                end
            end
        end
        if (bus.i_imem_wr && !bus.i_enable) m_mem[bus.i_imem_addr] = bus.i_imem_data;
        @(posedge clk);
        #1;
        check("pc",    bus.o_pc,          m_pc);
        check("instr", bus.o_ifid_instr,  m_instr);
        check("pc4",   bus.o_ifid_pc4,    m_pc4);
        check("halt",  {31'd0, bus.o_halt}, {31'd0, m_halt});
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        bus.i_imem_wr = 1; bus.i_imem_addr = idx[7:0]; bus.i_imem_data = data;
        tick();
        bus.i_imem_wr = 0;
    endtask

    initial begin
        logic [31:0] w;
        rst = 1;
        set_in(0, 0, 0, 2'b00, 0, 0, 0);
        bus.i_imem_wr = 0; bus.i_imem_addr = 0; bus.i_imem_data = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'hx;
        m_pc = 'x; m_instr = 'x; m_pc4 = 'x; m_halt = 'x;
        #2;
        tick();
        check("rst_pc", bus.o_pc, 32'h0);
        check("rst_halt", {31'd0, bus.o_halt}, 32'h0);
        rst = 0;

        // Load the whole array with non-halt filler, then the demo program.
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w == c_HALT) w = 32'h0;
            load(i, w);
        end
        load(0, 32'h2001_0005);
        load(1, 32'h2002_0007);
        load(2, 32'h0022_1820);
        load(3, c_HALT);

        set_in(1, 0, 0, 2'b00, 0, 0, 0);
        tick(); check("p1_instr", bus.o_ifid_instr, 32'h2001_0005); check("p1_pc4", bus.o_ifid_pc4, 32'h4);
        tick(); check("p2_pc4", bus.o_ifid_pc4, 32'h8);
        tick(); check("p3_instr", bus.o_ifid_instr, 32'h0022_1820); check("p3_pc4", bus.o_ifid_pc4, 32'hC);
        tick(); check("p4_halt", {31'd0, bus.o_halt}, 32'h1); check("p4_pc", bus.o_pc, 32'hC);

        // Jump and stall are ignored while halted; reset clears, memory survives.
        set_in(1, 1, 1, 2'b01, 32'h40, 0, 0);
        tick(); tick();
        check("halt_pc_hold", bus.o_pc, 32'hC);
        rst = 1; set_in(0, 0, 0, 2'b00, 0, 0, 0);
        tick();
        rst = 0;
        load(3, 32'h0000_0000);
        load(4, 32'h1234_5678);
        set_in(1, 0, 0, 2'b00, 0, 0, 0);
        tick();
        check("retain_instr", bus.o_ifid_instr, 32'h2001_0005);
        tick(); tick(); tick();
        check("at_10", bus.o_pc, 32'h10);

        set_in(1, 0, 1, 2'b01, 32'h40, 0, 0);
        tick();
        check("jdir_pc", bus.o_pc, 32'h40);
        check("dslot_instr", bus.o_ifid_instr, 32'h1234_5678);
        check("dslot_pc4", bus.o_ifid_pc4, 32'h14);
        set_in(1, 0, 1, 2'b10, 0, 32'h23, 0);
        tick(); check("jreg_pc", bus.o_pc, 32'h20);
        set_in(1, 0, 1, 2'b11, 0, 0, 32'h80);
        tick(); check("jbr_pc", bus.o_pc, 32'h80);
        set_in(1, 0, 0, 2'b11, 32'h40, 32'h40, 32'h40);
        tick(); check("seq_pc", bus.o_pc, 32'h84);
        set_in(1, 1, 0, 2'b00, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("stall_pc", bus.o_pc, 32'h84);
        set_in(1, 0, 0, 2'b00, 0, 0, 0);
        tick(); check("resume_pc", bus.o_pc, 32'h88);

        // Random phase: the model tracks every write, jump, stall and reset.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 2) == 0, 2'($urandom),
                   $urandom & 32'h3FF, $urandom, ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF));
            bus.i_imem_wr   = ($urandom_range(0, 3) == 0);
            bus.i_imem_addr = 8'($urandom);
            bus.i_imem_data = ($urandom_range(0, 15) == 0) ? c_HALT : $urandom;
            if (bus.i_imem_data == c_HALT && $urandom_range(0, 1) == 0) bus.i_imem_data = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It holds the PC and a word-addressed instruction memory that the debug unit loads. It selects the next PC from the next-PC-source and jump-control fields that the ID stage produces, and drives the IF/ID pipeline register consumed by the ID stage. It also implements stall, step-enable and sticky HALT detection.

## Interface
Parameters:
- `DATA_W`, 32, width of instruction and PC.
- `IMEM_DEPTH`, 256, instruction memory depth in words (power of two).
- `HALT_CODE`, 32'hFFFF_FFFF, instruction word that halts fetch.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock, all state updates on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  pipeline step enable from debug unit; 0 freezes all state.
- `i_stall`  in  1  load-use stall from hazard unit; holds PC and IF/ID.
- `i_next_pc_src`  in  1  0 = sequential, 1 = not sequential (ID control bit 14).
- `i_jmp_ctrl`  in  2  jump kind (ID control bits 13:12).
- `i_jmp_dir_addr`  in  DATA_W  J/JAL target computed in ID.
- `i_jmp_reg_addr`  in  DATA_W  JR/JALR target (rs value).
- `i_branch_addr`  in  DATA_W  taken-branch target.
- `i_imem_wr`  in  1  debug write strobe.
- `i_imem_addr`  in  $clog2(IMEM_DEPTH)  debug write word index.
- `i_imem_data`  in  DATA_W  debug write data.
- `o_pc`  out  DATA_W  current PC (debug view); reset 0.
- `o_ifid_instr`  out  DATA_W  IF/ID instruction; reset 0 (NOP).
- `o_ifid_pc4`  out  DATA_W  IF/ID PC+4; reset 0.
- `o_halt`  out  1  sticky halt flag; reset 0.

## Operation
- Memory read is asynchronous: `fetched = imem[pc[ADDR_W+1:2]]`. The index wraps by truncation.
- Memory writes happen on the clock edge when `i_imem_wr` = 1 and `i_enable` = 0. Writes with `i_enable` = 1 are ignored.
- Memory contents are not cleared by reset.
- Jump encodings, shared with the ID stage: `NOT_JMP` = 00, `JMP_DIR` = 01, `JMP_REG` = 10, `JMP_BRANCH` = 11.
- Next-PC rule: if `i_next_pc_src` = 0 or `i_jmp_ctrl` = `NOT_JMP`, next PC = PC + 4, modulo 2^32. Otherwise next PC is the selected target with bits [1:0] forced to 00.
- Per-edge priority, highest first:
  - reset: PC, IF/ID and `o_halt` go to 0.
  - `i_enable` = 0: all state holds.
  - `o_halt` = 1: all state holds.
  - `fetched == HALT_CODE`: IF/ID captures {HALT_CODE, PC+4}, PC holds, `o_halt` is set. A simultaneous jump request is ignored.
  - `i_stall` = 1: PC and IF/ID hold.
  - Otherwise: IF/ID captures {fetched, PC+4} and PC takes next PC.
- Branch delay slot: a jump resolved in ID redirects only the PC. The instruction fetched in that same cycle (the delay slot) is latched into IF/ID normally; there is no flush.
- State machine, two states:
  - `RUN` → `HALTED` on HALT fetch with enable and no reset.
  - `HALTED` → `RUN` only on reset. `o_halt` = (state == `HALTED`).

## Timing
- Latency: an instruction at PC p appears on `o_ifid_instr` one enabled, non-stalled edge after PC = p. `o_ifid_pc4` = p+4 at the same edge.
- A jump presented in cycle n makes PC = target after edge n. The target's instruction reaches IF/ID after edge n+1.
- A stall held for k enabled cycles freezes PC and IF/ID for exactly k edges. No instruction is lost or duplicated.
- Reset asserted mid-run or while `HALTED` clears everything at the next edge, regardless of `i_enable`.
- A debug write to the word the PC currently addresses is visible combinationally after that edge.

## Structure
- Shared package/header holds:
  - the jump encodings `NOT_JMP`, `JMP_DIR`, `JMP_REG`, `JMP_BRANCH`
  - `NEXT_PC_SRC_SEQ` / `NEXT_PC_SRC_NOT_SEQ`
  - `HALT_CODE`
  - the state encodings `RUN` / `HALTED`

  These are the same constants the ID control decoder uses.
- One sub-module: `instr_mem`, with an asynchronous-read, synchronous-write word array of `IMEM_DEPTH`.
- The PC mux, FSM and IF/ID register live in `if_stage`.

## Test plan
- Reset, load imem[0..3] = 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF, then enable → IF/ID sees the three instructions with pc4 = 4, 8, 12. `o_halt` rises on the 4th edge and PC stays at 0x0C.
- PC = 0x10, `i_next_pc_src` = 1, `i_jmp_ctrl` = 01, `i_jmp_dir_addr` = 0x40 → PC = 0x40 next edge. The delay-slot word at 0x10 is still latched with pc4 = 0x14.
- `JMP_REG` with `i_jmp_reg_addr` = 0x23 → PC = 0x20 (low bits cleared). `JMP_BRANCH` with `i_branch_addr` = 0x80 → PC = 0x80. Jump-control bits set with `i_next_pc_src` = 0 → PC + 4.
- Stall held 3 cycles at PC = 0x08 → PC and IF/ID unchanged for 3 edges, then resume at 0x0C.
- `i_enable` = 0 for 5 cycles, including a debug write to index 2 → no state change. The write takes effect; writes with `i_enable` = 1 are dropped.
- While `HALTED`, assert a jump and a stall, then `i_reset` for one cycle → jump and stall are ignored while halted. Reset returns PC, IF/ID and `o_halt` to 0, and the imem contents are retained.
